// File: rtl/writeback_arb_pkg.sv
`default_nettype none
// writeback_arb_pkg: shared types, default sizes and helpers for the orion writeback stage.
package writeback_arb_pkg;

  localparam int ORION_XLEN        = 32;
  localparam int ORION_RF_IDX_BITS = 5;

  localparam int WB_NUM_SRC    = 3;
  localparam int WB_NUM_WP     = 1;
  localparam int WB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [ORION_RF_IDX_BITS-1:0] rd_s;
    logic [ORION_XLEN-1:0]        rd_v;
    logic                         rd_we;
  } wb_entry_t;

  function automatic int wrap_add(input int base, input int offset, input int modulus);
    return (base + offset) % modulus;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_arb_fifo.sv
`default_nettype none
// wb_fifo: small synchronous FIFO of writeback entries with count-based full/empty.
module wb_fifo
  import writeback_arb_pkg::*;
#(
  parameter int  DEPTH = WB_FIFO_DEPTH,
  parameter type T     = wb_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/writeback_arb.sv
`default_nettype none
// writeback_arb: per-source result FIFOs drained round-robin onto registered RF write ports,
// with same-destination conflict skipping and a 64-bit retired-result counter.
module writeback_arb
  import writeback_arb_pkg::*;
#(
  parameter int XLEN        = ORION_XLEN,
  parameter int RF_IDX_BITS = ORION_RF_IDX_BITS,
  parameter int NUM_SRC     = WB_NUM_SRC,
  parameter int NUM_WP      = WB_NUM_WP,
  parameter int FIFO_DEPTH  = WB_FIFO_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  input  logic [NUM_SRC*RF_IDX_BITS-1:0] src_rd_s_i,
  input  logic [NUM_SRC*XLEN-1:0]       src_rd_v_i,
  input  logic [NUM_SRC-1:0]            src_rd_we_i,
  output logic [NUM_WP-1:0]             wp_we_o,
  output logic [NUM_WP*RF_IDX_BITS-1:0] wp_rd_s_o,
  output logic [NUM_WP*XLEN-1:0]        wp_rd_v_o,
  output logic [63:0]                   retire_cnt_o
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int GW = $clog2(NUM_WP + 1);

  typedef struct packed {
    logic [RF_IDX_BITS-1:0] rd_s;
    logic [XLEN-1:0]        rd_v;
    logic                   rd_we;
  } entry_t;

  entry_t             heads [NUM_SRC];
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] grant;

  logic [SW-1:0]      rr_q;
  logic [SW-1:0]      idx;
  logic [SW-1:0]      last_idx;
  logic [GW-1:0]      n_grant;
  logic [NUM_WP-1:0]  port_vld;
  entry_t             port_ent [NUM_WP];
  logic               conflict;

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      entry_t in_ent;

      assign in_ent.rd_s  = src_rd_s_i[k*RF_IDX_BITS +: RF_IDX_BITS];
      assign in_ent.rd_v  = src_rd_v_i[k*XLEN +: XLEN];
      assign in_ent.rd_we = src_rd_we_i[k];

      wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
      ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (src_valid_i[k]),
        .push_data (in_ent),
        .pop       (grant[k]),
        .full      (full[k]),
        .empty     (empty[k]),
        .head      (heads[k])
      );
    end
  endgenerate

  assign src_ready_o = ~full;

  // Scan heads from rr_q; a head whose destination is already being written this cycle
  // is skipped without stopping the scan, so later sources can still fill free ports.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    n_grant  = '0;
    last_idx = rr_q;
    idx      = rr_q;
    conflict = 1'b0;
    for (int p = 0; p < NUM_WP; p++) begin
      port_ent[p] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      idx      = SW'(wrap_add(int'(rr_q), i, NUM_SRC));
      conflict = 1'b0;
      if (heads[idx].rd_we && (heads[idx].rd_s != '0)) begin
        for (int p = 0; p < NUM_WP; p++) begin
          if (port_vld[p] && port_ent[p].rd_we && (port_ent[p].rd_s == heads[idx].rd_s)) begin
            conflict = 1'b1;
          end
        end
      end
      if (!empty[idx] && (n_grant < GW'(NUM_WP)) && !conflict) begin
        for (int p = 0; p < NUM_WP; p++) begin
          if (n_grant == GW'(p)) begin
            port_vld[p] = 1'b1;
            port_ent[p] = heads[idx];
          end
        end
        grant[idx] = 1'b1;
        n_grant    = n_grant + GW'(1);
        last_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_q         <= '0;
      retire_cnt_o <= '0;
      wp_we_o      <= '0;
      wp_rd_s_o    <= '0;
      wp_rd_v_o    <= '0;
    end else begin
      if (|grant) begin
        rr_q <= (last_idx == SW'(NUM_SRC - 1)) ? '0 : last_idx + SW'(1);
      end
      retire_cnt_o <= retire_cnt_o + 64'(n_grant);
      for (int p = 0; p < NUM_WP; p++) begin
        if (port_vld[p]) begin
          // x0 and non-writing results still retire, just with the enable low.
          wp_we_o[p]                                <= port_ent[p].rd_we && (port_ent[p].rd_s != '0);
          wp_rd_s_o[p*RF_IDX_BITS +: RF_IDX_BITS]  <= port_ent[p].rd_s;
          wp_rd_v_o[p*XLEN +: XLEN]                <= port_ent[p].rd_v;
        end else begin
          wp_we_o[p] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arb.sv
`default_nettype none
`timescale 1ns/1ps
// tb_writeback_arb: directed checks of the writeback arbiter with one- and two-port instances.
module tb_writeback_arb;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;

  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [14:0] rds;
  logic [95:0] rdv;
  logic [2:0]  we_in;
  logic [0:0]  wp_we;
  logic [4:0]  wp_rd_s;
  logic [31:0] wp_rd_v;
  logic [63:0] retire;

  logic [2:0]  valid2;
  logic [2:0]  ready2;
  logic [14:0] rds2;
  logic [95:0] rdv2;
  logic [2:0]  we_in2;
  logic [1:0]  wp_we2;
  logic [9:0]  wp_rd_s2;
  logic [63:0] wp_rd_v2;
  logic [63:0] retire2;

  int checks = 0;
  int errors = 0;

  writeback_arb #(.NUM_SRC(3), .NUM_WP(1), .FIFO_DEPTH(2)) dut1 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .src_valid_i  (valid),
    .src_ready_o  (ready),
    .src_rd_s_i   (rds),
    .src_rd_v_i   (rdv),
    .src_rd_we_i  (we_in),
    .wp_we_o      (wp_we),
    .wp_rd_s_o    (wp_rd_s),
    .wp_rd_v_o    (wp_rd_v),
    .retire_cnt_o (retire)
  );

  writeback_arb #(.NUM_SRC(3), .NUM_WP(2), .FIFO_DEPTH(2)) dut2 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .src_valid_i  (valid2),
    .src_ready_o  (ready2),
    .src_rd_s_i   (rds2),
    .src_rd_v_i   (rdv2),
    .src_rd_we_i  (we_in2),
    .wp_we_o      (wp_we2),
    .wp_rd_s_o    (wp_rd_s2),
    .wp_rd_v_o    (wp_rd_v2),
    .retire_cnt_o (retire2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int ch, input logic [4:0] rd, input logic [31:0] v, input logic w);
    valid[ch]         = 1'b1;
    rds[ch*5 +: 5]    = rd;
    rdv[ch*32 +: 32]  = v;
    we_in[ch]         = w;
  endtask

  task automatic drive2(input int ch, input logic [4:0] rd, input logic [31:0] v, input logic w);
    valid2[ch]        = 1'b1;
    rds2[ch*5 +: 5]   = rd;
    rdv2[ch*32 +: 32] = v;
    we_in2[ch]        = w;
  endtask

  task automatic idle();
    valid  = '0;
    valid2 = '0;
  endtask

  initial begin
    // Reset held 3 cycles with every producer asserting valid.
    rst_i  = 1'b0;
    valid  = 3'b111;
    rds    = '1;
    rdv    = '1;
    we_in  = 3'b111;
    valid2 = 3'b111;
    rds2   = '1;
    rdv2   = '1;
    we_in2 = 3'b111;
    repeat (3) step();
    chk("reset_we", 64'(wp_we), 64'h0);
    chk("reset_rd_s", 64'(wp_rd_s), 64'h0);
    chk("reset_rd_v", 64'(wp_rd_v), 64'h0);
    chk("reset_cnt", retire, 64'h0);
    chk("reset_we2", 64'(wp_we2), 64'h0);
    rst_i = 1'b1;
    idle();
    chk("ready_after_release", 64'(ready), 64'h7);
    step();
    chk("no_write_after_release", 64'(wp_we), 64'h0);

    // Round-robin wave from rr=0: rd 1, 2, 3 in order.
    drive(0, 5'd1, 32'h11, 1'b1);
    drive(1, 5'd2, 32'h22, 1'b1);
    drive(2, 5'd3, 32'h33, 1'b1);
    step();
    idle();
    chk("rr1_t1_idle", 64'(wp_we), 64'h0);
    step();
    chk("rr1_w0_we", 64'(wp_we), 64'h1);
    chk("rr1_w0_rd", 64'(wp_rd_s), 64'd1);
    step();
    chk("rr1_w1_rd", 64'(wp_rd_s), 64'd2);
    step();
    chk("rr1_w2_rd", 64'(wp_rd_s), 64'd3);
    chk("rr1_w2_v", 64'(wp_rd_v), 64'h33);
    chk("rr1_cnt", retire, 64'd3);
    step();
    chk("rr1_done", 64'(wp_we), 64'h0);

    // Single result from ch0: visible exactly in cycle t+2.
    drive(0, 5'd5, 32'hDEADBEEF, 1'b1);
    step();
    idle();
    chk("single_t1_we", 64'(wp_we), 64'h0);
    step();
    chk("single_t2_we", 64'(wp_we), 64'h1);
    chk("single_t2_rd", 64'(wp_rd_s), 64'd5);
    chk("single_t2_v", 64'(wp_rd_v), 64'hDEADBEEF);
    chk("single_cnt", retire, 64'd4);
    step();
    chk("single_t3_we", 64'(wp_we), 64'h0);
    chk("single_t3_hold", 64'(wp_rd_s), 64'd5);

    // Next wave starts after ch0 (last grant): order ch1, ch2, ch0.
    drive(0, 5'd9, 32'h99, 1'b1);
    drive(1, 5'd10, 32'hAA, 1'b1);
    drive(2, 5'd11, 32'hBB, 1'b1);
    step();
    idle();
    step();
    chk("rr2_first", 64'(wp_rd_s), 64'd10);
    step();
    chk("rr2_second", 64'(wp_rd_s), 64'd11);
    step();
    chk("rr2_third", 64'(wp_rd_s), 64'd9);
    chk("rr2_cnt", retire, 64'd7);
    step();
    chk("rr2_done", 64'(wp_we), 64'h0);

    // x0 write and rd_we=0 entry: drained with enable low, still retired.
    drive(0, 5'd0, 32'h55, 1'b1);
    drive(1, 5'd4, 32'h66, 1'b0);
    step();
    idle();
    step();
    chk("nowr_a_we", 64'(wp_we), 64'h0);
    chk("nowr_a_cnt", retire, 64'd8);
    step();
    chk("nowr_b_we", 64'(wp_we), 64'h0);
    chk("nowr_b_cnt", retire, 64'd9);

    // Backpressure: ch1 offers rd 11,12,13,14 while ch0 (rd 20) and ch2 (rd 22) saturate.
    drive(0, 5'd20, 32'h200, 1'b1);
    drive(2, 5'd22, 32'h220, 1'b1);
    drive(1, 5'd11, 32'h110, 1'b1);
    step();
    drive(1, 5'd12, 32'h120, 1'b1);
    step();
    chk("bp_e1_rd", 64'(wp_rd_s), 64'd11);
    chk("bp_e1_ready", 64'(ready), 64'h2);
    drive(1, 5'd13, 32'h130, 1'b1);
    step();
    chk("bp_e2_rd", 64'(wp_rd_s), 64'd22);
    chk("bp_e2_ready", 64'(ready), 64'h4);
    drive(1, 5'd14, 32'h140, 1'b1);
    step();
    idle();
    chk("bp_e3_rd", 64'(wp_rd_s), 64'd20);
    chk("bp_e3_ready", 64'(ready), 64'h1);
    step();
    chk("bp_e4_rd", 64'(wp_rd_s), 64'd12);
    chk("bp_e4_v", 64'(wp_rd_v), 64'h120);
    chk("bp_e4_ready", 64'(ready), 64'h3);
    step();
    chk("bp_e5_rd", 64'(wp_rd_s), 64'd22);
    step();
    chk("bp_e6_rd", 64'(wp_rd_s), 64'd20);
    step();
    chk("bp_e7_rd", 64'(wp_rd_s), 64'd13);
    chk("bp_e7_we", 64'(wp_we), 64'h1);
    step();
    chk("bp_e8_rd", 64'(wp_rd_s), 64'd22);
    chk("bp_e8_cnt", retire, 64'd17);
    step();
    chk("bp_e9_we", 64'(wp_we), 64'h0);
    chk("bp_e9_cnt", retire, 64'd17);

    // Two ports: ch0 and ch1 both target rd 7; ch2 (rd 9) takes port 1.
    drive2(0, 5'd7, 32'hA1, 1'b1);
    drive2(1, 5'd7, 32'hB2, 1'b1);
    drive2(2, 5'd9, 32'hC3, 1'b1);
    step();
    idle();
    chk("cf_t1_we", 64'(wp_we2), 64'h0);
    step();
    chk("cf_t2_we", 64'(wp_we2), 64'h3);
    chk("cf_t2_rd", 64'(wp_rd_s2), 64'({5'd9, 5'd7}));
    chk("cf_t2_v", wp_rd_v2, {32'hC3, 32'hA1});
    chk("cf_t2_cnt", retire2, 64'd2);
    step();
    chk("cf_t3_we", 64'(wp_we2), 64'h1);
    chk("cf_t3_rd", 64'(wp_rd_s2), 64'({5'd9, 5'd7}));
    chk("cf_t3_v", wp_rd_v2, {32'hC3, 32'hB2});
    chk("cf_t3_cnt", retire2, 64'd3);
    step();
    chk("cf_t4_we", 64'(wp_we2), 64'h0);

    // Mid-stream reset: queued results must be discarded.
    drive(0, 5'd30, 32'h300, 1'b1);
    drive(1, 5'd31, 32'h310, 1'b1);
    drive(2, 5'd29, 32'h290, 1'b1);
    step();
    idle();
    rst_i = 1'b0;
    step();
    chk("mrst_we", 64'(wp_we), 64'h0);
    chk("mrst_cnt", retire, 64'h0);
    chk("mrst_rd_s", 64'(wp_rd_s), 64'h0);
    rst_i = 1'b1;
    step();
    chk("mrst_p1_we", 64'(wp_we), 64'h0);
    step();
    chk("mrst_p2_we", 64'(wp_we), 64'h0);
    step();
    chk("mrst_p3_we", 64'(wp_we), 64'h0);
    chk("mrst_p3_cnt", retire, 64'h0);
    chk("mrst_p3_ready", 64'(ready), 64'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
